lsu_split_ctrl: RTL and testbench

- Load/store control stage sitting between the EX/MEM pipeline register and the data memory.
- Accepts one memory request at a time over a valid/ready handshake and drives the data memory port (wr_en, funct3, address, write data, combinational read data).
- Aligned requests pass through as a single access.
- Misaligned halfword/word requests are split into sequential byte accesses; load bytes are reassembled and sign/zero-extended.
- Asserts busy so the hazard unit can stall the pipeline.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_extend.sv | 17 +
 rtl/lsu_split_ctrl.sv | 143 ++++++++++++++
 tb/tb_lsu_split_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM state codes and size/alignment helpers
// for the load/store split controller.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Access size in bytes; 0 marks an illegal funct3.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_LB, F3_LBU: size = 3'd1;
      F3_LH, F3_LHU: size = 3'd2;
      F3_LW:         size = 3'd4;
      default:       size = 3'd0;
    endcase
    return size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    logic mis;
    case (size)
      3'd2:    mis = addr_lo[0];
      3'd4:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend: sign/zero extends the low 1, 2 or 4 bytes of a raw 32-bit value.
module lsu_extend (
  input  logic [31:0] raw,
  input  logic [2:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  always_comb begin
    case (size)
      3'd1:    ext = is_unsigned ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      3'd2:    ext = is_unsigned ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_split_ctrl.sv
// lsu_split_ctrl: load/store stage that splits misaligned halfword/word accesses into byte accesses.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned requests with resp_err instead of splitting them.
module lsu_split_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);
  import lsu_pkg::*;

  logic [1:0]            state_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            size_q;
  logic                  mis_q;
  logic                  err_q;
  logic [1:0]            idx_q;
  logic [DATA_WIDTH-1:0] result_q;

  logic [2:0]            req_size;
  logic                  req_mis;
  logic                  req_err;
  logic [7:0]            wr_byte;
  logic [DATA_WIDTH-1:0] ext_data;

  assign req_size = access_size(req_funct3);
  assign req_mis  = is_misaligned(req_addr[1:0], req_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = (req_size == 3'd0) || req_mis;
`else
  assign req_err = (req_size == 3'd0);
`endif

  assign wr_byte = wdata_q[8*idx_q +: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 3'd0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= 2'd0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= req_size;
            mis_q    <= req_mis;
            err_q    <= req_err;
            idx_q    <= 2'd0;
            result_q <= '0;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (err_q) begin
            state_q <= DONE;
          end else if (!mis_q) begin
            result_q <= mem_rd_data;
            state_q  <= DONE;
          end else begin
            // Split path: one byte lane per cycle, reassembled little-endian.
            if (!we_q)
              result_q[8*idx_q +: 8] <= mem_rd_data[7:0];
            if ({1'b0, idx_q} == size_q - 3'd1)
              state_q <= DONE;
            else
              idx_q <= idx_q + 2'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port defaults to a harmless byte read; reset forces every output to zero.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_funct3  = F3_LBU;
    mem_addr    = addr_q;
    mem_wr_data = '0;
    if (state_q == ACCESS && !err_q) begin
      mem_wr_en = we_q;
      if (mis_q) begin
        mem_funct3  = we_q ? F3_SB : F3_LBU;
        mem_addr    = addr_q + ADDR_WIDTH'(idx_q);
        mem_wr_data = {{(DATA_WIDTH-8){1'b0}}, wr_byte};
      end else begin
        mem_funct3  = funct3_q;
        mem_wr_data = wdata_q;
      end
    end
    if (reset) begin
      mem_wr_en   = 1'b0;
      mem_funct3  = 3'b000;
      mem_addr    = '0;
      mem_wr_data = '0;
    end
  end

  lsu_extend u_extend (
    .raw         (result_q),
    .size        (size_q),
    .is_unsigned (funct3_q[2]),
    .ext         (ext_data)
  );

  assign req_ready  = !reset && (state_q == IDLE);
  assign busy       = !reset && (state_q != IDLE);
  assign resp_valid = !reset && (state_q == DONE);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? ext_data : '0;

endmodule

// File: tb/tb_lsu_split_ctrl.sv
// tb_lsu_split_ctrl: directed self-checking bench with a byte-addressed memory model and a
// response scoreboard; define LSU_MISALIGN_TRAP_EN to check the trap build instead of splitting.
module tb_lsu_split_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        mem_wr_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [7:0] mem [0:255];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;
  logic [7:0] ra;

  lsu_split_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .busy        (busy),
    .mem_wr_en   (mem_wr_en),
    .mem_funct3  (mem_funct3),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Little-endian data memory with combinational, already-extended read data.
  always_comb begin
    ra = mem_addr[7:0];
    case (mem_funct3)
      3'b000:  mem_rd_data = {{24{mem[ra][7]}}, mem[ra]};
      3'b001:  mem_rd_data = {{16{mem[ra+8'd1][7]}}, mem[ra+8'd1], mem[ra]};
      3'b010:  mem_rd_data = {mem[ra+8'd3], mem[ra+8'd2], mem[ra+8'd1], mem[ra]};
      3'b100:  mem_rd_data = {24'b0, mem[ra]};
      3'b101:  mem_rd_data = {16'b0, mem[ra+8'd1], mem[ra]};
      default: mem_rd_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_wr_en) begin
      case (mem_funct3)
        3'b000: mem[mem_addr[7:0]] <= mem_wr_data[7:0];
        3'b001: begin
          mem[mem_addr[7:0]]       <= mem_wr_data[7:0];
          mem[mem_addr[7:0]+8'd1]  <= mem_wr_data[15:8];
        end
        3'b010: begin
          mem[mem_addr[7:0]]       <= mem_wr_data[7:0];
          mem[mem_addr[7:0]+8'd1]  <= mem_wr_data[15:8];
          mem[mem_addr[7:0]+8'd2]  <= mem_wr_data[23:16];
          mem[mem_addr[7:0]+8'd3]  <= mem_wr_data[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Responses are popped in order; a missing or early/late pulse shows up as a cycle mismatch.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        checkOutput("resp_missing_cycle", cyc, e.due);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("resp_unexpected", {31'b0, resp_valid}, 32'h0);
        end else begin
          e = sb.pop_front();
          checkOutput("resp_cycle", cyc, e.due);
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Drives one request, waits (bounded) for acceptance and queues the expected response.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit expect_resp,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int lat, output int acc);
    int waited;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    acc = cyc;
    if (!req_ready) begin
      checkOutput("req_ready_timeout", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b0;
    end else begin
      if (expect_resp) sb.push_back('{exp_rdata, exp_err, cyc + lat});
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && (busy || sb.size() > 0); k++) @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", {31'b0, resp_err}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'h0);
    checkOutput("rst_mem_funct3", {29'b0, mem_funct3}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wr_data", mem_wr_data, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("idle_mem_funct3", {29'b0, mem_funct3}, 32'h4);

    // Aligned SW then LW back.
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0, 2, n);
    @(negedge clk);
    checkOutput("asw_wr_en", {31'b0, mem_wr_en}, 32'h1);
    checkOutput("asw_funct3", {29'b0, mem_funct3}, 32'h2);
    checkOutput("asw_addr", mem_addr, 32'h10);
    checkOutput("asw_wdata", mem_wr_data, 32'hDEADBEEF);
    checkOutput("asw_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    checkOutput("asw_done_wr_en", {31'b0, mem_wr_en}, 32'h0);
    checkOutput("asw_done_ready", {31'b0, req_ready}, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0, 2, n);

    // Illegal funct3 load and store.
    applyStimulus(1'b0, 3'b011, 32'h40, 32'h0, 1, 32'h0, 1'b1, 2, n);
    @(negedge clk);
    checkOutput("ill_ld_wr_en", {31'b0, mem_wr_en}, 32'h0);
    applyStimulus(1'b1, 3'b110, 32'h40, 32'h000000FF, 1, 32'h0, 1'b1, 2, n);
    @(negedge clk);
    checkOutput("ill_st_wr_en", {31'b0, mem_wr_en}, 32'h0);
    drain();

`ifndef LSU_MISALIGN_TRAP_EN
    // Misaligned SW split into four byte writes.
    applyStimulus(1'b1, 3'b010, 32'h13, 32'h11223344, 1, 32'h0, 1'b0, 5, n);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checkOutput("msw_busy", {31'b0, busy}, 32'h1);
      if (i <= 4) begin
        checkOutput("msw_wr_en", {31'b0, mem_wr_en}, 32'h1);
        checkOutput("msw_funct3", {29'b0, mem_funct3}, 32'h0);
        checkOutput("msw_addr", mem_addr, 32'h12 + 32'(i));
        checkOutput("msw_wdata", mem_wr_data, (32'h11223344 >> (8 * (i - 1))) & 32'hFF);
      end
    end
    drain();
    checkOutput("msw_mem13", {24'b0, mem[8'h13]}, 32'h44);
    checkOutput("msw_mem16", {24'b0, mem[8'h16]}, 32'h11);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 1, 32'h44, 1'b0, 2, n);
    applyStimulus(1'b0, 3'b101, 32'h15, 32'h0, 1, 32'h1122, 1'b0, 3, n);
    applyStimulus(1'b0, 3'b010, 32'h13, 32'h0, 1, 32'h11223344, 1'b0, 5, n);

    // Misaligned LH/LHU sign and zero extension.
    drain();
    preload(8'h21, 8'h80);
    preload(8'h22, 8'hFF);
    applyStimulus(1'b0, 3'b001, 32'h21, 32'h0, 1, 32'hFFFFFF80, 1'b0, 3, n);
    applyStimulus(1'b0, 3'b101, 32'h21, 32'h0, 1, 32'h0000FF80, 1'b0, 3, n);

    // Split halfword wrapping past the top of the address space.
    applyStimulus(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, 1, 32'h0, 1'b0, 3, n);
    @(negedge clk);
    checkOutput("wrap_addr0", mem_addr, 32'hFFFFFFFF);
    @(negedge clk);
    checkOutput("wrap_addr1", mem_addr, 32'h0);
    checkOutput("wrap_wdata1", mem_wr_data, 32'hBE);
    applyStimulus(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, 1, 32'h0000BEEF, 1'b0, 3, n);
    applyStimulus(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 1, 32'hFFFFBEEF, 1'b0, 3, n);

    // Reset in the second access cycle of a split store aborts it silently.
    drain();
    for (int a = 8'h13; a <= 8'h16; a++) preload(8'(a), 8'h00);
    applyStimulus(1'b1, 3'b010, 32'h13, 32'hAABBCCDD, 0, 32'h0, 1'b0, 0, n);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rmid_wr_en", {31'b0, mem_wr_en}, 32'h0);
    checkOutput("rmid_resp_valid", {31'b0, resp_valid}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rmid_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("rmid_busy", {31'b0, busy}, 32'h0);
    checkOutput("rmid_mem13", {24'b0, mem[8'h13]}, 32'hDD);
    checkOutput("rmid_mem14", {24'b0, mem[8'h14]}, 32'h00);
    checkOutput("rmid_mem15", {24'b0, mem[8'h15]}, 32'h00);
    checkOutput("rmid_mem16", {24'b0, mem[8'h16]}, 32'h00);
    repeat (3) @(negedge clk);
`else
    // Trap build: misaligned requests are rejected without touching memory.
    preload(8'h13, 8'h00);
    applyStimulus(1'b1, 3'b010, 32'h13, 32'h11223344, 1, 32'h0, 1'b1, 2, n);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checkOutput("trap_sw_wr_en", {31'b0, mem_wr_en}, 32'h0);
    end
    drain();
    checkOutput("trap_sw_mem13", {24'b0, mem[8'h13]}, 32'h00);
    preload(8'h14, 8'h01);
    preload(8'h15, 8'h02);
    preload(8'h16, 8'h03);
    preload(8'h17, 8'h04);
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 1, 32'h04030201, 1'b0, 2, n);
    applyStimulus(1'b0, 3'b001, 32'h21, 32'h0, 1, 32'h0, 1'b1, 2, n);
`endif

    drain();
    checkOutput("sb_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
